// File: rtl/param_processor.sv
// param_processor: multi-cycle accumulator-style processor with an NREGS x DATA_W register file,
// 8-op ALU, Z/N/C flags and a run/done handshake. Define PARAM_PROC_MULT_EN to build the multiplier.
module param_processor #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic [DATA_W-1:0]        instr,
    input  logic [$clog2(NREGS)-1:0] rd_sel,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     busy,
    output logic                     done,
    output logic                     illegal,
    output logic                     flag_z,
    output logic                     flag_n,
    output logic                     flag_c
);

    localparam int unsigned RW    = $clog2(NREGS);
    localparam int unsigned IMM_W = DATA_W - 4 - RW;
    localparam int unsigned EXT_W = DATA_W - IMM_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOADA = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_WB    = 2'd3;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MULT = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_CMP  = 3'b111;

`ifdef PARAM_PROC_MULT_EN
    localparam bit MULT_EN = 1'b1;
`else
    localparam bit MULT_EN = 1'b0;
`endif

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] regs [NREGS];

    logic              ir_ld;
    logic              a_ld;
    logic              exec_en;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;
    logic              busy_nxt;
    logic              done_nxt;
    logic              illegal_nxt;

    // Instruction field decode from the latched IR
    logic [2:0]        op_c;
    logic              m_c;
    logic [RW-1:0]     rx_c;
    logic [IMM_W-1:0]  d_c;
    logic [DATA_W-1:0] operand_c;
    logic [2:0]        instr_op_c;
    logic              instr_ill_c;
    logic              ir_ill_c;

    assign op_c       = ir[DATA_W-1 -: 3];
    assign m_c        = ir[DATA_W-4];
    assign rx_c       = ir[DATA_W-5 -: RW];
    assign d_c        = ir[IMM_W-1:0];
    assign operand_c  = m_c ? {{EXT_W{d_c[IMM_W-1]}}, d_c} : regs[d_c[RW-1:0]];
    assign instr_op_c = instr[DATA_W-1 -: 3];

    // Multiply opcode is rejected when the multiplier is not built
    assign instr_ill_c = !MULT_EN && (instr_op_c == OP_MULT);
    assign ir_ill_c    = !MULT_EN && (op_c == OP_MULT);

    assign rd_data = regs[rd_sel];

    // ALU: result and carry/borrow for the op in IR
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic [DATA_W:0]   sum_c;
    logic [DATA_W:0]   diff_c;
`ifdef PARAM_PROC_MULT_EN
    logic [2*DATA_W-1:0] prod_c;
`endif

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        sum_c   = {1'b0, a} + {1'b0, operand_c};
        diff_c  = {1'b0, a} - {1'b0, operand_c};
`ifdef PARAM_PROC_MULT_EN
        prod_c  = (2*DATA_W)'(a) * (2*DATA_W)'(operand_c);
`endif
        case (op_c)
            OP_ADD: begin
                alu_res = sum_c[DATA_W-1:0];
                alu_c   = sum_c[DATA_W];
            end
            OP_SUB, OP_CMP: begin
                alu_res = diff_c[DATA_W-1:0];
                alu_c   = diff_c[DATA_W];
            end
`ifdef PARAM_PROC_MULT_EN
            OP_MULT: begin
                alu_res = prod_c[DATA_W-1:0];
                alu_c   = |prod_c[2*DATA_W-1:DATA_W];
            end
`endif
            OP_AND:  alu_res = a & operand_c;
            OP_OR:   alu_res = a | operand_c;
            OP_XOR:  alu_res = a ^ operand_c;
            default: alu_res = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and datapath controls; done/illegal are computed one cycle ahead and registered
    always_comb begin
        state_nxt   = state;
        ir_ld       = 1'b0;
        a_ld        = 1'b0;
        exec_en     = 1'b0;
        rf_we       = 1'b0;
        rf_wdata    = '0;
        done_nxt    = 1'b0;
        illegal_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) begin
                    ir_ld       = 1'b1;
                    state_nxt   = S_LOADA;
                    done_nxt    = (instr_op_c == OP_MV) || instr_ill_c;
                    illegal_nxt = instr_ill_c;
                end
            end
            S_LOADA: begin
                if (op_c == OP_MV) begin
                    rf_we     = 1'b1;
                    rf_wdata  = operand_c;
                    state_nxt = S_IDLE;
                end else if (ir_ill_c) begin
                    state_nxt = S_IDLE;
                end else begin
                    a_ld      = 1'b1;
                    state_nxt = S_EXEC;
                    done_nxt  = (op_c == OP_CMP);
                end
            end
            S_EXEC: begin
                exec_en = 1'b1;
                if (op_c == OP_CMP) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_WB;
                    done_nxt  = 1'b1;
                end
            end
            S_WB: begin
                rf_we     = 1'b1;
                rf_wdata  = r;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        busy_nxt = (state_nxt != S_IDLE);
    end

    // Datapath registers, flags and handshake outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir      <= '0;
            a       <= '0;
            r       <= '0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            flag_c  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[RW'(i)] <= '0;
            end
        end else begin
            busy    <= busy_nxt;
            done    <= done_nxt;
            illegal <= illegal_nxt;
            if (ir_ld) begin
                ir <= instr;
            end
            if (a_ld) begin
                a <= regs[rx_c];
            end
            if (exec_en) begin
                r      <= alu_res;
                flag_z <= (alu_res == '0);
                flag_n <= alu_res[DATA_W-1];
                flag_c <= alu_c;
            end
            if (rf_we) begin
                regs[rx_c] <= rf_wdata;
            end
        end
    end

endmodule

// File: tb/tb_param_processor.sv
// Directed self-checking bench for param_processor (DATA_W=16, NREGS=4).
// Expectations follow PARAM_PROC_MULT_EN when the multiply vector runs.
module tb_param_processor;

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic        run    = 1'b0;
    logic [15:0] instr  = 16'h0000;
    logic [1:0]  rd_sel = 2'd0;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;
    logic        illegal;
    logic        flag_z;
    logic        flag_n;
    logic        flag_c;

    int errors = 0;
    int checks = 0;

    param_processor #(
        .DATA_W(16),
        .NREGS (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .run    (run),
        .instr  (instr),
        .rd_sel (rd_sel),
        .rd_data(rd_data),
        .busy   (busy),
        .done   (done),
        .illegal(illegal),
        .flag_z (flag_z),
        .flag_n (flag_n),
        .flag_c (flag_c)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input logic [1:0] sel, input logic [15:0] exp, input string tag);
        rd_sel = sel;
        #1;
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic chk_flags(input string tag, input logic z, input logic n, input logic c);
        check({tag, ".z"}, 32'(flag_z), 32'(z));
        check({tag, ".n"}, 32'(flag_n), 32'(n));
        check({tag, ".c"}, 32'(flag_c), 32'(c));
    endtask

    // Issue one instruction, measure cycles from accept edge to done, then confirm a one-cycle pulse
    task automatic exec(input string tag, input logic [15:0] ins, input int exp_lat,
                        input logic exp_ill, input bit pulse);
        int   lat;
        logic ill;
        lat = 0;
        ill = 1'b0;
        @(negedge clk);
        run   = 1'b1;
        instr = ins;
        @(posedge clk);
        #1;
        run   = 1'b0;
        instr = 16'($urandom);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check({tag, ".busy"}, 32'(busy), 32'd1);
                if (pulse) begin
                    run   = 1'b1;
                    instr = 16'h3401;
                end
            end else begin
                run = 1'b0;
            end
            if (done) begin
                lat = n;
                ill = illegal;
                break;
            end
        end
        run = 1'b0;
        check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check({tag, ".ill"}, 32'(ill), 32'(exp_ill));
        @(negedge clk);
        check({tag, ".pulse"}, 32'(done), 32'd0);
        check({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    logic seen;

    initial begin
        repeat (2) @(negedge clk);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.ill", 32'(illegal), 32'd0);
        chk_flags("rst", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) chk_reg(2'(i), 16'h0000, "rst.reg");
        reset = 1'b1;

        exec("mv_r1", 16'h15FF, 1, 1'b0, 1'b0);
        chk_reg(2'd1, 16'h01FF, "mv_r1.val");
        exec("add_r1", 16'h3401, 3, 1'b0, 1'b0);
        chk_reg(2'd1, 16'h0200, "add_r1.val");
        chk_flags("add_r1", 1'b0, 1'b0, 1'b0);

        exec("mv_r0", 16'h1000, 1, 1'b0, 1'b0);
        exec("sub_r0", 16'h5001, 3, 1'b0, 1'b1);
        chk_reg(2'd0, 16'hFFFF, "sub_r0.val");
        chk_reg(2'd1, 16'h0200, "sub_r0.no_rerun");
        chk_flags("sub_r0", 1'b0, 1'b1, 1'b1);

        // mv r2,#-3 encodes as op=000 M=1 rX=2 D=0x3FD
        exec("mv_r2", 16'h1BFD, 1, 1'b0, 1'b0);
        chk_reg(2'd2, 16'hFFFD, "mv_r2.val");
        chk_flags("mv_r2", 1'b0, 1'b1, 1'b1);

        exec("mv_r0_7", 16'h1007, 1, 1'b0, 1'b0);
        exec("mv_r1_7", 16'h1407, 1, 1'b0, 1'b0);
        exec("cmp", 16'hE001, 2, 1'b0, 1'b0);
        chk_flags("cmp", 1'b1, 1'b0, 1'b0);
        chk_reg(2'd0, 16'h0007, "cmp.r0");

        exec("sub_self", 16'h4000, 3, 1'b0, 1'b0);
        chk_reg(2'd0, 16'h0000, "sub_self.val");
        chk_flags("sub_self", 1'b1, 1'b0, 1'b0);

        exec("add_carry", 16'h3803, 3, 1'b0, 1'b0);
        chk_reg(2'd2, 16'h0000, "add_carry.val");
        chk_flags("add_carry", 1'b1, 1'b0, 1'b1);

        exec("mv_r3", 16'h1FFF, 1, 1'b0, 1'b0);
        chk_reg(2'd3, 16'hFFFF, "mv_r3.val");
        exec("xor_r3", 16'hDD55, 3, 1'b0, 1'b0);
        chk_reg(2'd3, 16'hFEAA, "xor_r3.val");
        chk_flags("xor_r3", 1'b0, 1'b1, 1'b0);
        exec("or_r0", 16'hA003, 3, 1'b0, 1'b0);
        chk_reg(2'd0, 16'hFEAA, "or_r0.val");
        chk_flags("or_r0", 1'b0, 1'b1, 1'b0);
        exec("and_r0", 16'h9100, 3, 1'b0, 1'b0);
        chk_reg(2'd0, 16'h0000, "and_r0.val");
        chk_flags("and_r0", 1'b1, 1'b0, 1'b0);

        exec("mv_r0_100", 16'h1100, 1, 1'b0, 1'b0);
        exec("mv_r1_100", 16'h1500, 1, 1'b0, 1'b0);
`ifdef PARAM_PROC_MULT_EN
        exec("mult", 16'h6001, 3, 1'b0, 1'b0);
        chk_reg(2'd0, 16'h0000, "mult.val");
        chk_flags("mult", 1'b1, 1'b0, 1'b1);
`else
        exec("mult", 16'h6001, 1, 1'b1, 1'b0);
        chk_reg(2'd0, 16'h0100, "mult.val");
        chk_flags("mult", 1'b1, 1'b0, 1'b0);
`endif

        // Abort an add in S_EXEC with reset
        @(negedge clk);
        run   = 1'b1;
        instr = 16'h3401;
        @(posedge clk);
        #1;
        run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort.busy_pre", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        check("abort.ill", 32'(illegal), 32'd0);
        chk_flags("abort", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) chk_reg(2'(i), 16'h0000, "abort.reg");
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | done | busy;
        end
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            seen = seen | done | busy;
        end
        check("abort.quiet", 32'(seen), 32'd0);
        chk_reg(2'd1, 16'h0000, "abort.r1_after");

        exec("mv_r3_post", 16'h1C05, 1, 1'b0, 1'b0);
        chk_reg(2'd3, 16'h0005, "mv_r3_post.val");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
